// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N clock controller with req/ack ratio load; optional tick via CLK_DIV_TICK_EN.
// Latency: clk_out high one edge after en; ratio load acks next edge (STOP) or at period wrap (RUN).
// Backpressure: cfg_req held until cfg_ack; a pending ratio blocks new requests until the wrap edge.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             busy,
  output logic             clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  typedef enum logic {STOP, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             clk_out_nxt, ack_nxt, err_nxt, tick_nxt;
  logic             take, bad_ratio, wrap;
  logic [DIV_W-1:0] cnt_inc;

  // A request is only looked at when nothing is in flight for it.
  assign take      = cfg_req & ~cfg_ack & ~pend_vld;
  assign bad_ratio = cfg_div < DIV_W'(2);
  assign wrap      = (cnt == div - DIV_W'(1));
  assign cnt_inc   = cnt + DIV_W'(1);
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_nxt      = div;
    pend_div_nxt = pend_div;
    pend_vld_nxt = pend_vld;
    clk_out_nxt  = 1'b0;
    ack_nxt      = 1'b0;
    err_nxt      = 1'b0;
    tick_nxt     = 1'b0;
    case (state)
      STOP: begin
        if (take) begin
          ack_nxt = 1'b1;
          if (bad_ratio) err_nxt = 1'b1;
          else           div_nxt = cfg_div;
        end
        // Start edge: any legal N >= 2 gives a high first cycle.
        if (en) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          clk_out_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end
      end
      RUN: begin
        if (take) begin
          if (bad_ratio) begin
            ack_nxt = 1'b1;
            err_nxt = 1'b1;
          end else begin
            pend_div_nxt = cfg_div;
            pend_vld_nxt = 1'b1;
          end
        end
        if (wrap) begin
          cnt_nxt = '0;
          if (pend_vld) begin
            div_nxt      = pend_div;
            pend_vld_nxt = 1'b0;
            ack_nxt      = 1'b1;
          end
          if (en) begin
            clk_out_nxt = 1'b1;
            tick_nxt    = 1'b1;
          end else begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt     = cnt_inc;
          clk_out_nxt = cnt_inc < (div >> 1);
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      cnt      <= '0;
      div      <= DIV_W'(DIV_DEFAULT);
      pend_div <= '0;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      pend_div <= pend_div_nxt;
      pend_vld <= pend_vld_nxt;
      clk_out  <= clk_out_nxt;
      cfg_ack  <= ack_nxt;
      cfg_err  <= err_nxt;
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= tick_nxt;
  end
`else
  logic unused_tick;
  assign unused_tick = tick_nxt;
`endif

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller generating a 50%-nominal-duty divided clock from the system clock. The divide ratio is runtime-configurable through a req/ack handshake. A run/stop control starts and stops the output. Ratio changes and stops take effect only at output-period boundaries, so `clk_out` never carries a runt pulse. It generalises the team's fixed divide-by-2/by-4 dividers into one sequenced, reconfigurable block that feeds downstream clock-enable and slow-clock consumers.

## Interface
Parameters:
- `DIV_W`, default 8: width of the divide ratio.
- `DIV_DEFAULT`, default 4: ratio loaded at reset. Must be between 2 and 2^DIV_W-1.

Ports:
- `clk`, in, 1: system clock. The only clock in the block; all logic is on its rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `en`, in, 1: run request. Level-sensitive.
- `cfg_req`, in, 1: request to load a new ratio. Held high until `cfg_ack`.
- `cfg_div`, in, DIV_W: requested ratio N. Must be stable while `cfg_req` is high.
- `cfg_ack`, out, 1: one-cycle pulse when the request is consumed.
- `cfg_err`, out, 1: one-cycle pulse coincident with `cfg_ack` when the request was rejected.
- `busy`, out, 1: high while in RUN.
- `clk_out`, out, 1: divided clock, registered.
- `tick`, out, 1: present only with `CLK_DIV_TICK_EN`. Single-cycle pulse at each period start.

## Operation
- Registers:
  - `div`: active ratio N.
  - `pend_div` and `pend_vld`: pending ratio and its valid flag.
  - `cnt`: period counter, width DIV_W, range 0..N-1, wraps to 0.
  - `state`: STOP or RUN.
- Reset values:
  - state=STOP, cnt=0, div=DIV_DEFAULT, pend_vld=0.
  - clk_out=0, busy=0, cfg_ack=0, cfg_err=0, tick=0.
- `clk_out` waveform:
  - In RUN, `clk_out`=1 when cnt < N>>1, otherwise 0. `cnt` and `clk_out` are updated on the same edge.
  - Result: N=4 gives 1100; N=5 gives 11000; N=2 gives 10; N=3 gives 100.
- STOP → RUN: taken on the edge where en=1. That edge loads cnt=0 and clk_out=1.
- RUN, en=1: cnt increments; at N-1 it wraps to 0.
- RUN, en=0: the current period completes. At the edge where cnt=N-1 the block enters STOP, with cnt=0 and clk_out=0. No truncated period is allowed.
- Configuration handshake:
  - `cfg_req` is sampled only when cfg_ack=0 and pend_vld=0.
  - If cfg_div<2: the request is rejected. `cfg_ack` and `cfg_err` pulse on the next edge; `div` is unchanged.
  - In STOP: div<=cfg_div and `cfg_ack` pulses on the next edge.
  - In RUN: the ratio is captured into `pend_div` with pend_vld=1. On the wrap edge (cnt=N-1): div<=pend_div, pend_vld<=0, and `cfg_ack` pulses. The new period uses the new N from its first cycle.
  - If en falls while pend_vld=1: the wrap edge both applies the ratio and enters STOP.
  - The requester deasserts `cfg_req` the cycle after `cfg_ack`. `cfg_req` is ignored while cfg_ack=1.
- `busy`=1 exactly when state=RUN.

## Timing
- en to first `clk_out` high: 1 edge.
- Config accepted in STOP: ack 1 edge after `cfg_req` is sampled.
- Config accepted in RUN: ack on the period-boundary edge, worst case N edges after sampling.
- en fall to STOP: up to N edges, always completing the period.
- Async `rst` asserted mid-period: all outputs go to their reset values immediately, without a clock edge. Any pending config is discarded with no ack. Release is synchronous to the next `clk` edge as seen by the logic.
- Simultaneous en rise and `cfg_req` in STOP: the ratio load and the start happen on the same edge. The first period uses the new N.

## Configuration
- `CLK_DIV_TICK_EN` defined:
  - The `tick` port exists.
  - tick=1 for the single cycle following each edge that sets cnt=0 in RUN. This is coincident with the first high cycle of `clk_out`.
  - Its purpose is to give downstream consumers a clock enable instead of using `clk_out` as a clock.
- `CLK_DIV_TICK_EN` undefined: the `tick` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then en=1 with default N=4 → `clk_out` 1,1,0,0 repeating; first high in the cycle after the en edge; busy=1.
- Running at N=4; at cnt=1 request cfg_div=5 → current period finishes (4 cycles); `cfg_ack` on the wrap edge; then 1,1,0,0,0 repeating.
- Request cfg_div=1 in STOP or RUN → cfg_ack=1 and cfg_err=1 for one cycle; N unchanged.
- N=6, drop en at cnt=2 → `clk_out` completes 1,1,1,0,0,0; then stays 0; busy=0 after the cnt=5 edge.
- Async rst pulse while clk_out=1 at N=7 → clk_out=0 and busy=0 with no clock edge; after release, en=1 produces the N=4 pattern.
- With `CLK_DIV_TICK_EN` and N=2 → tick=1 every other cycle, aligned with clk_out=1; after switching to N=3, tick every third cycle.
